// File: rtl/sid_env_pkg.sv
// rtl/sid_env_pkg.sv - shared stage encoding, voice state type and rate tables for the SID envelope scheduler
package sid_env_pkg;

  // Register block stride between consecutive voices on the bus
  localparam int VOICE_STRIDE = 7;

  // One-hot-ish stage encoding; any other value is treated as illegal
  localparam logic [2:0] STG_ATT     = 3'd1;
  localparam logic [2:0] STG_DEC_SUS = 3'd2;
  localparam logic [2:0] STG_REL     = 3'd4;

  typedef struct packed {
    logic [2:0]  stage;
    logic [7:0]  env;
    logic [14:0] cnt;
    logic [4:0]  div;
  } voice_state_t;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_V0, SEQ_V1, SEQ_V2} seq_state_t;

  // Rate counter reload value for each of the 16 ADSR rate codes
  function automatic logic [14:0] cnt_max(input logic [3:0] rate);
    case (rate)
      4'd0:    cnt_max = 15'd8;
      4'd1:    cnt_max = 15'd31;
      4'd2:    cnt_max = 15'd62;
      4'd3:    cnt_max = 15'd94;
      4'd4:    cnt_max = 15'd148;
      4'd5:    cnt_max = 15'd219;
      4'd6:    cnt_max = 15'd266;
      4'd7:    cnt_max = 15'd312;
      4'd8:    cnt_max = 15'd391;
      4'd9:    cnt_max = 15'd976;
      4'd10:   cnt_max = 15'd1953;
      4'd11:   cnt_max = 15'd3125;
      4'd12:   cnt_max = 15'd3906;
      4'd13:   cnt_max = 15'd11719;
      4'd14:   cnt_max = 15'd19531;
      default: cnt_max = 15'd31250;
    endcase
  endfunction

  // Exponential divider reload: lower envelope levels step more slowly
  function automatic logic [4:0] div_max(input logic [7:0] env);
    if (env >= 8'h5E)      div_max = 5'd1;
    else if (env >= 8'h37) div_max = 5'd2;
    else if (env >= 8'h1B) div_max = 5'd4;
    else if (env >= 8'h0F) div_max = 5'd8;
    else if (env >= 8'h07) div_max = 5'd16;
    else if (env >= 8'h01) div_max = 5'd30;
    else                   div_max = 5'd1;
  endfunction

endpackage

// File: rtl/sid_env_step.sv
// rtl/sid_env_step.sv - combinational one-voice envelope step (state + ADSR + gate -> next state)
module sid_env_step
  import sid_env_pkg::*;
(
  input  voice_state_t i_cur,
  input  logic [3:0]   i_att,
  input  logic [3:0]   i_dec,
  input  logic [3:0]   i_sus,
  input  logic [3:0]   i_rel,
  input  logic         i_gate,
  output voice_state_t o_next
);

  logic [3:0] w_rate;
  logic       w_rate_tick;
  logic       w_div_tick;

  // Advance rate counter and divider, then apply the stage rules
  always_comb begin
    o_next      = i_cur;
    w_rate      = i_rel;
    w_rate_tick = 1'b0;
    w_div_tick  = 1'b0;

    case (i_cur.stage)
      STG_ATT:     w_rate = i_att;
      STG_DEC_SUS: w_rate = i_dec;
      default:     w_rate = i_rel;
    endcase

    if (i_cur.cnt == 15'd0) begin
      w_rate_tick = 1'b1;
      o_next.cnt  = cnt_max(w_rate);
    end else begin
      o_next.cnt  = i_cur.cnt - 15'd1;
    end

    if (w_rate_tick) begin
      if (i_cur.div == 5'd0) begin
        w_div_tick = 1'b1;
        o_next.div = div_max(i_cur.env);
      end else begin
        o_next.div = i_cur.div - 5'd1;
      end
    end

    case (i_cur.stage)
      STG_REL: begin
        if (i_gate) o_next.stage = STG_ATT;
        else if (w_div_tick && i_cur.env != 8'h00) o_next.env = i_cur.env - 8'd1;
      end
      STG_ATT: begin
        if (!i_gate) o_next.stage = STG_REL;
        else if (i_cur.env == 8'hFF) o_next.stage = STG_DEC_SUS;
        else if (w_rate_tick) o_next.env = i_cur.env + 8'd1;
      end
      STG_DEC_SUS: begin
        if (!i_gate) o_next.stage = STG_REL;
        else if (w_div_tick && i_cur.env != {i_sus, i_sus} && i_cur.env != 8'h00)
          o_next.env = i_cur.env - 8'd1;
      end
      default: begin
        // Recover from a corrupted stage without touching level or counters
        o_next       = i_cur;
        o_next.stage = STG_REL;
      end
    endcase
  end

endmodule

// File: rtl/sid_env_sched.sv
// rtl/sid_env_sched.sv - three-voice envelope scheduler sharing one step datapath; SID_ENV_SCHED_READBACK_EN enables ENV2 readback on DOUT
module sid_env_sched
  import sid_env_pkg::*;
#(
  parameter int BASE_ADDR = 0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       CLKen,
  input  logic       WR,
  input  logic [4:0] ADDR,
  input  logic [7:0] DATA,
  input  logic       RD,
  output logic [7:0] ENV0,
  output logic [7:0] ENV1,
  output logic [7:0] ENV2,
  output logic [7:0] DOUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVERRUN
);

  voice_state_t r_voice [3];
  logic [3:0]   r_att   [3];
  logic [3:0]   r_dec   [3];
  logic [3:0]   r_sus   [3];
  logic [3:0]   r_rel   [3];
  logic [2:0]   r_gate;

  seq_state_t   r_state;
  logic         r_pending;
  logic         r_busy;
  logic         r_done;
  logic         r_overrun;

  logic [2:0]   w_hit_gate;
  logic [2:0]   w_hit_ad;
  logic [2:0]   w_hit_sr;
  logic [1:0]   w_idx;
  voice_state_t w_cur;
  voice_state_t w_next;
  logic [3:0]   w_att;
  logic [3:0]   w_dec;
  logic [3:0]   w_sus;
  logic [3:0]   w_rel;
  logic         w_gate;

  // Decode bus writes into per-voice register hits
  always_comb begin
    w_hit_gate = '0;
    w_hit_ad   = '0;
    w_hit_sr   = '0;
    for (int v = 0; v < 3; v++) begin
      w_hit_gate[v] = WR && (int'(ADDR) == BASE_ADDR + v * VOICE_STRIDE + 4);
      w_hit_ad[v]   = WR && (int'(ADDR) == BASE_ADDR + v * VOICE_STRIDE + 5);
      w_hit_sr[v]   = WR && (int'(ADDR) == BASE_ADDR + v * VOICE_STRIDE + 6);
    end
  end

  // Route the voice owning the current slot into the shared step
  always_comb begin
    w_idx = 2'd0;
    case (r_state)
      SEQ_V1:  w_idx = 2'd1;
      SEQ_V2:  w_idx = 2'd2;
      default: w_idx = 2'd0;
    endcase
    w_cur  = r_voice[0];
    w_att  = r_att[0];
    w_dec  = r_dec[0];
    w_sus  = r_sus[0];
    w_rel  = r_rel[0];
    w_gate = r_gate[0];
    for (int v = 1; v < 3; v++) begin
      if (w_idx == 2'(v)) begin
        w_cur  = r_voice[v];
        w_att  = r_att[v];
        w_dec  = r_dec[v];
        w_sus  = r_sus[v];
        w_rel  = r_rel[v];
        w_gate = r_gate[v];
      end
    end
  end

  sid_env_step u_step (
    .i_cur  (w_cur),
    .i_att  (w_att),
    .i_dec  (w_dec),
    .i_sus  (w_sus),
    .i_rel  (w_rel),
    .i_gate (w_gate),
    .o_next (w_next)
  );

  // ADSR and gate register file; the step sees the pre-write value on a colliding edge
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_gate <= '0;
      for (int v = 0; v < 3; v++) begin
        r_att[v] <= 4'd0;
        r_dec[v] <= 4'd0;
        r_sus[v] <= 4'd0;
        r_rel[v] <= 4'd0;
      end
    end else begin
      for (int v = 0; v < 3; v++) begin
        if (w_hit_gate[v]) r_gate[v] <= DATA[0];
        if (w_hit_ad[v]) begin
          r_att[v] <= DATA[7:4];
          r_dec[v] <= DATA[3:0];
        end
        if (w_hit_sr[v]) begin
          r_sus[v] <= DATA[7:4];
          r_rel[v] <= DATA[3:0];
        end
      end
    end
  end

  // Voice state storage: the active voice is rewritten on the edge leaving its slot
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int v = 0; v < 3; v++)
        r_voice[v] <= '{stage: STG_REL, env: 8'd0, cnt: 15'd0, div: 5'd0};
    end else begin
      for (int v = 0; v < 3; v++)
        if (r_state != SEQ_IDLE && w_idx == 2'(v)) r_voice[v] <= w_next;
    end
  end

  // Sweep sequencer with a one-deep tick queue and sticky overrun flag
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= SEQ_IDLE;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (CLKen) begin
            r_state <= SEQ_V0;
            r_busy  <= 1'b1;
          end
        end
        SEQ_V0: r_state <= SEQ_V1;
        SEQ_V1: r_state <= SEQ_V2;
        SEQ_V2: begin
          r_done <= 1'b1;
          // A tick landing on the last slot is swept straight away rather than parked
          if (r_pending || CLKen) begin
            r_state   <= SEQ_V0;
            r_pending <= 1'b0;
          end else begin
            r_state <= SEQ_IDLE;
            r_busy  <= 1'b0;
          end
          if (r_pending && CLKen) r_overrun <= 1'b1;
        end
        default: begin
          r_state <= SEQ_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (CLKen && (r_state == SEQ_V0 || r_state == SEQ_V1)) begin
        if (!r_pending) r_pending <= 1'b1;
        else            r_overrun <= 1'b1;
      end
    end
  end

  assign ENV0    = r_voice[0].env;
  assign ENV1    = r_voice[1].env;
  assign ENV2    = r_voice[2].env;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign OVERRUN = r_overrun;

`ifdef SID_ENV_SCHED_READBACK_EN
  logic [7:0] r_dout;

  // Register ENV2 onto the read port when its readback address is read
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_dout <= 8'd0;
    else if (RD && int'(ADDR) == BASE_ADDR + 28) r_dout <= r_voice[2].env;
    else r_dout <= 8'd0;
  end

  assign DOUT = r_dout;
`else
  logic w_unused_rd;
  assign w_unused_rd = RD;
  assign DOUT        = 8'd0;
`endif

endmodule

// File: tb/tb_sid_env_sched.sv
// tb/tb_sid_env_sched.sv - self-checking bench for sid_env_sched with a per-tick ADSR reference model
module tb_sid_env_sched;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       CLKen = 1'b0;
  logic       WR = 1'b0;
  logic       RD = 1'b0;
  logic [4:0] ADDR = 5'd0;
  logic [7:0] DATA = 8'd0;
  logic [7:0] ENV0, ENV1, ENV2, DOUT;
  logic       BUSY, DONE, OVERRUN;

  int checks = 0;
  int errors = 0;

  sid_env_sched #(.BASE_ADDR(0)) dut (
    .CLK(CLK), .RSTn(RSTn), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA), .RD(RD),
    .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2), .DOUT(DOUT),
    .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Reference model: one record of ints per voice, advanced once per tick
  int cnt_tab [16] = '{8, 31, 62, 94, 148, 219, 266, 312, 391, 976, 1953, 3125, 3906, 11719, 19531, 31250};
  localparam int M_ATT = 0, M_DEC = 1, M_REL = 2;
  int m_stage [3], m_env [3], m_cnt [3], m_div [3];
  int m_att [3], m_dec [3], m_sus [3], m_rel [3], m_gate [3];

  typedef struct {
    bit   wr;
    int   addr;
    int   data;
    int   ticks;
    int   e0, e1, e2;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dmax(input int e);
    if (e >= 94) return 1;
    if (e >= 55) return 2;
    if (e >= 27) return 4;
    if (e >= 15) return 8;
    if (e >= 7)  return 16;
    if (e >= 1)  return 30;
    return 1;
  endfunction

  task automatic model_reset;
    for (int v = 0; v < 3; v++) begin
      m_stage[v] = M_REL; m_env[v] = 0; m_cnt[v] = 0; m_div[v] = 0;
      m_att[v] = 0; m_dec[v] = 0; m_sus[v] = 0; m_rel[v] = 0; m_gate[v] = 0;
    end
  endtask

  task automatic model_write(input int a, input int d);
    int v, off;
    v = a / 7; off = a % 7;
    if (v < 3) begin
      if (off == 4) m_gate[v] = d & 1;
      if (off == 5) begin m_att[v] = (d >> 4) & 15; m_dec[v] = d & 15; end
      if (off == 6) begin m_sus[v] = (d >> 4) & 15; m_rel[v] = d & 15; end
    end
  endtask

  task automatic model_step(input int v);
    int rate;
    bit rt, dt;
    rate = (m_stage[v] == M_ATT) ? m_att[v] : (m_stage[v] == M_DEC) ? m_dec[v] : m_rel[v];
    rt = (m_cnt[v] == 0);
    dt = 0;
    if (rt) begin
      m_cnt[v] = cnt_tab[rate];
      if (m_div[v] == 0) begin dt = 1; m_div[v] = dmax(m_env[v]); end
      else m_div[v] = m_div[v] - 1;
    end else begin
      m_cnt[v] = m_cnt[v] - 1;
    end
    if (m_stage[v] == M_REL) begin
      if (m_gate[v] != 0) m_stage[v] = M_ATT;
      else if (dt && m_env[v] > 0) m_env[v] = m_env[v] - 1;
    end else if (m_stage[v] == M_ATT) begin
      if (m_gate[v] == 0) m_stage[v] = M_REL;
      else if (m_env[v] == 255) m_stage[v] = M_DEC;
      else if (rt) m_env[v] = m_env[v] + 1;
    end else begin
      if (m_gate[v] == 0) m_stage[v] = M_REL;
      else if (dt && m_env[v] != m_sus[v] * 17 && m_env[v] != 0) m_env[v] = m_env[v] - 1;
    end
  endtask

  task automatic model_tick;
    for (int v = 0; v < 3; v++) model_step(v);
  endtask

  // All stimulus tasks start and end just after a falling edge
  task automatic bus_write(input int a, input int d);
    WR = 1'b1; ADDR = 5'(a); DATA = 8'(d);
    @(negedge CLK);
    WR = 1'b0;
    model_write(a, d);
  endtask

  task automatic tick;
    CLKen = 1'b1;
    @(negedge CLK);
    CLKen = 1'b0;
    repeat (3) @(negedge CLK);
    model_tick();
  endtask

  task automatic chk_envs(input string tag);
    chk({tag, "_env0"}, ENV0, m_env[0]);
    chk({tag, "_env1"}, ENV1, m_env[1]);
    chk({tag, "_env2"}, ENV2, m_env[2]);
  endtask

  task automatic run_ticks(input int n, input int every, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      if ((i + 1) % every == 0 || i == n - 1) chk_envs(tag);
    end
  endtask

  task automatic do_reset;
    RSTn = 1'b0; CLKen = 1'b0; WR = 1'b0; RD = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    model_reset();
  endtask

  initial begin
    vec_t vec [6];
    bit lat_busy [5] = '{1, 1, 1, 0, 0};
    bit lat_done [5] = '{0, 0, 0, 1, 0};
    bit b2b_busy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    bit b2b_done [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    bit b2b_ovr  [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    int a, d, off, v;

    vec[0] = '{1'b1, 11, 8'h01, 1,  0, 0,  0};
    vec[1] = '{1'b0, 0,  0,     9,  0, 1,  0};
    vec[2] = '{1'b0, 0,  0,     9,  0, 2,  0};
    vec[3] = '{1'b1, 5,  8'h10, 90, 0, 12, 0};
    vec[4] = '{1'b1, 4,  8'h01, 1,  0, 12, 0};
    vec[5] = '{1'b0, 0,  0,     20, 1, 14, 0};

    do_reset();
    chk("rst_env0", ENV0, 0);
    chk("rst_env1", ENV1, 0);
    chk("rst_env2", ENV2, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_dout", DOUT, 0);

    // Single tick: BUSY for three slots, DONE once after the last one
    CLKen = 1'b1;
    @(negedge CLK);
    CLKen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lat_busy%0d", k), BUSY, lat_busy[k]);
      chk($sformatf("lat_done%0d", k), DONE, lat_done[k]);
      @(negedge CLK);
    end

    // Table of writes and tick counts with hand-derived envelope levels
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (vec[i].wr) bus_write(vec[i].addr, vec[i].data);
      repeat (vec[i].ticks) tick();
      chk($sformatf("vec%0d_env0", i), ENV0, vec[i].e0);
      chk($sformatf("vec%0d_env1", i), ENV1, vec[i].e1);
      chk($sformatf("vec%0d_env2", i), ENV2, vec[i].e2);
    end

    // Reset in the middle of a sweep clears state and the sweep does not resume
    CLKen = 1'b1;
    @(negedge CLK);
    CLKen = 1'b0;
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_env0", ENV0, 0);
    chk("midrst_env1", ENV1, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (4) @(negedge CLK);
    chk("midrst_busy_after", BUSY, 0);
    chk("midrst_done_after", DONE, 0);
    model_reset();

    // Three back-to-back ticks: second queued, third dropped with OVERRUN
    bus_write(11, 1);
    CLKen = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (k == 2) CLKen = 1'b0;
      chk($sformatf("b2b_busy%0d", k), BUSY, b2b_busy[k]);
      chk($sformatf("b2b_done%0d", k), DONE, b2b_done[k]);
      chk($sformatf("b2b_ovr%0d", k), OVERRUN, b2b_ovr[k]);
    end
    model_tick();
    model_tick();
    chk_envs("b2b");
    tick();
    chk("ovr_sticky", OVERRUN, 1);
    chk_envs("b2b_after");

    // Full attack, decay to sustain 0x88, then release to zero
    do_reset();
    bus_write(5, 8'h00);
    bus_write(6, 8'h80);
    bus_write(4, 1);
    bus_write(11, 1);
    bus_write(19, 8'h00);
    bus_write(20, 8'h80);
    bus_write(18, 1);
    run_ticks(2296, 100, "att");
    chk("peak_env0", ENV0, 255);
    chk("peak_env1", ENV1, 255);
    chk("peak_env2", ENV2, 255);
    run_ticks(3100, 100, "dec");
    chk("sus_env0", ENV0, 8'h88);
    chk("sus_env2", ENV2, 8'h88);
    bus_write(18, 0);
    run_ticks(3000, 100, "rel_a");
    run_ticks(4600, 100, "rel_b");
    chk("rel_env2_zero", ENV2, 0);
    chk("rel_env0_hold", ENV0, 8'h88);

    // Randomised register writes between ticks, checked every sweep
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        v = $urandom_range(0, 2);
        off = $urandom_range(4, 6);
        if (off == 4)      d = $urandom_range(0, 1);
        else if (off == 5) d = ($urandom_range(0, 3) << 4) | $urandom_range(0, 3);
        else               d = ($urandom_range(0, 15) << 4) | $urandom_range(0, 3);
        a = v * 7 + off;
        bus_write(a, d);
      end
      tick();
      chk("rnd_done", DONE, 1);
      chk_envs($sformatf("rnd%0d", i));
    end

    // Readback of ENV2 through DOUT
    RD = 1'b1;
    ADDR = 5'h1C;
    @(negedge CLK);
    RD = 1'b0;
`ifdef SID_ENV_SCHED_READBACK_EN
    chk("rb_dout", DOUT, m_env[2]);
`else
    chk("rb_dout", DOUT, 0);
`endif
    @(negedge CLK);
    chk("rb_dout_idle", DOUT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_env_sched.md
# sid_env_sched

Time-multiplexed envelope scheduler for the three SID voices. Holds the per-voice ADSR and gate registers, plus envelope state (stage, level, rate counter, exponential divider). On every 1 MHz CLKen tick it sequences one shared envelope-step datapath across voices 0, 1 and 2 on consecutive CLK cycles. It sits between the SID register bus and the voice mixers, replacing three independent envelope instances with one arithmetic path.

## Interface
- BASE_ADDR, 0, bus address of voice 0's register block; voice v registers sit at BASE_ADDR+7*v.
- CLK  in  1  master clock; must run at least 4x the CLKen rate.
- RSTn  in  1  asynchronous active-low reset.
- CLKen  in  1  1 MHz single-cycle tick.
- WR  in  1  bus write strobe.
- ADDR  in  5  bus address.
- DATA  in  8  bus write data.
- RD  in  1  bus read strobe (used only with readback).
- ENV0, ENV1, ENV2  out  8 each  registered envelope levels.
- DOUT  out  8  readback data.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  one-cycle pulse after voice 2 has been written.
- OVERRUN  out  1  sticky; a tick arrived while one was already pending.

## Operation
- Register decode per voice v, applied on WR at the next CLK edge:
  - offset +4: DATA[0] → gate.
  - offset +5: DATA[7:4] → ATT, DATA[3:0] → DEC.
  - offset +6: DATA[7:4] → SUS, DATA[3:0] → REL.
- Sequencer FSM states: IDLE, V0, V1, V2.
  - IDLE --CLKen--> V0, V0 → V1, V1 → V2.
  - V2 → V0 if pending, clearing pending; otherwise V2 → IDLE.
  - Voice n's state is written on the edge leaving Vn.
- Step function, applied to the selected voice:
  - cnt: if cnt==0, rate_tick=1 and cnt ← cnt_max(rate); else cnt ← cnt-1.
  - Rate source: ATT in ATT stage, DEC in DEC_SUS, REL in REL.
  - cnt_max for rate 0..15: 8, 31, 62, 94, 148, 219, 266, 312, 391, 976, 1953, 3125, 3906, 11719, 19531, 31250.
  - div: on rate_tick, if div==0, div_tick=1 and div ← div_max(env); else div ← div-1.
  - div_max by env range: 0x5E–0xFF→1, 0x37–0x5D→2, 0x1B–0x36→4, 0x0F–0x1A→8, 0x07–0x0E→16, 0x01–0x06→30, 0x00→1.
- Stage transitions, evaluated only in the voice's update slot:
  - REL: gate=1 → ATT with env unchanged this slot. Otherwise, on div_tick, env ← env-1, saturating at 0.
  - ATT: gate=0 → REL. Otherwise env==0xFF → DEC_SUS. Otherwise, on rate_tick, env ← env+1.
  - DEC_SUS: gate=0 → REL. Otherwise, on div_tick, env ← env-1 unless env=={SUS,SUS} or env==0.
  - Illegal stage encoding → REL.
- Arithmetic: cnt is 15 bits, div 5 bits, env 8 bits. Nothing wraps; env saturates at 0x00 and 0xFF.

## Timing
- Reset values:
  - All env 0, all stages REL, all cnt and div 0.
  - All ADSR and gate registers 0.
  - FSM IDLE, pending 0.
  - All outputs 0: ENV0–2, DOUT, BUSY, DONE, OVERRUN.
- Tick to output latency: CLKen sampled at edge E0; ENV0 updates at E1, ENV1 at E2, ENV2 at E3. DONE is high for the cycle after E3.
- BUSY = (state != IDLE).
- CLKen while not IDLE:
  - If pending==0, set pending.
  - Otherwise set OVERRUN and drop the tick.
- Simultaneous register write and update slot of the same voice: the step uses the old register value; the write lands on the same edge.
- RSTn assertion mid-sweep clears everything immediately; the sweep does not resume.

## Configuration
- SID_ENV_SCHED_READBACK_EN defined: when RD is high and ADDR==BASE_ADDR+0x1C, DOUT is registered with ENV2 on the next edge. Otherwise DOUT is 0.
- Macro undefined: DOUT is tied to 0 and RD is ignored.

## Structure
- Shared package sid_env_pkg holds:
  - Stage encoding (ATT=1, DEC_SUS=2, REL=4).
  - cnt_max and div_max lookup functions.
  - Per-voice state struct {stage, env, cnt, div}.
  - Voice register stride constant (7).
- One sub-module, sid_env_step: purely combinational next-state function (state + ADSR + gate → next state). sid_env_sched owns all storage and the sequencer.

## Test plan
- Reset → ENV0–2=0, BUSY=0, OVERRUN=0. A tick produces DONE 4 cycles after CLKen, with BUSY high for 3 cycles.
- Voice 1: ATT=0, gate=1 → ENV1 reaches 0xFF after 256×9 ticks; stage moves to DEC_SUS and ENV0 and ENV2 stay 0.
- Voice 0: DEC=0, SUS=8, gate held after peak → ENV0 decays and holds at 0x88.
- Voice 2 at 0x88, gate cleared, REL=0 → ENV2 reaches 0 and stays 0. Step intervals lengthen as div_max follows the ranges above.
- CLKen on 3 consecutive CLK cycles → the second tick is queued and swept immediately after V2; the third sets OVERRUN, which stays set until RSTn.
- With SID_ENV_SCHED_READBACK_EN, ENV2=0x42, RD with ADDR=0x1C → DOUT=0x42 next cycle. Without the macro → DOUT=0.
